// File: rtl/usb_fs_pad_seq.sv
// USB full-speed host pad sequencer: times pre-encoded line-state bits onto the
// D+/D- tristate pads, appends EOP, holds a turnaround guard and drives bus reset.
module usb_fs_pad_seq #(
  parameter int unsigned CLKS_PER_BIT    = 4,
  parameter int unsigned TURNAROUND_BITS = 2,
  parameter int unsigned RESET_CYCLES    = 480000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic       tx_bit,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       eop_done,
  input  logic       bus_reset_req,
  output logic       bus_reset_done,
  output logic       busy,
  output logic [1:0] line_state,
  output logic       dp_o,
  output logic       dm_o,
  output logic       dp_t,
  output logic       dm_t,
  input  logic       dp_i,
  input  logic       dm_i
);

  localparam int unsigned EopSe0Cycles = 2 * CLKS_PER_BIT;
  localparam int unsigned GuardCycles  = TURNAROUND_BITS * CLKS_PER_BIT;
  localparam int unsigned MaxA         = (EopSe0Cycles > GuardCycles) ? EopSe0Cycles : GuardCycles;
  localparam int unsigned MaxCnt       = (RESET_CYCLES > MaxA) ? RESET_CYCLES : MaxA;
  localparam int unsigned CntW         = $clog2(MaxCnt);

  localparam logic [CntW-1:0] BitEnd   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] Se0End   = CntW'(EopSe0Cycles - 1);
  localparam logic [CntW-1:0] GuardEnd = CntW'(GuardCycles - 1);
  localparam logic [CntW-1:0] RstEnd   = CntW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxData,
    StEopSe0,
    StEopJ,
    StGuard,
    StBusRst
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bit_q, bit_d;
  logic            last_q, last_d;
  logic            pad_t_q, pad_t_d;
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic [1:0]      sync1_q, sync2_q;

  // Next-state, bit latch and single-cycle handshake/pulse outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CntW'(1);
    bit_d          = bit_q;
    last_d         = last_q;
    tx_ready       = 1'b0;
    tx_underrun    = 1'b0;
    eop_done       = 1'b0;
    bus_reset_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Bus reset wins over a simultaneous transmit request.
        if (bus_reset_req) begin
          state_d = StBusRst;
        end else if (tx_valid) begin
          tx_ready = 1'b1;
          bit_d    = tx_bit;
          last_d   = tx_last;
          state_d  = StTxData;
        end
      end
      StTxData: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = StEopSe0;
          end else if (tx_valid) begin
            tx_ready = 1'b1;
            bit_d    = tx_bit;
            last_d   = tx_last;
          end else begin
            // Serializer starved: close the packet with EOP anyway.
            tx_underrun = 1'b1;
            state_d     = StEopSe0;
          end
        end
      end
      StEopSe0: begin
        if (cnt_q == Se0End) begin
          cnt_d   = '0;
          state_d = StEopJ;
        end
      end
      StEopJ: begin
        if (cnt_q == BitEnd) begin
          eop_done = 1'b1;
          cnt_d    = '0;
          state_d  = StGuard;
        end
      end
      StGuard: begin
        if (cnt_q == GuardEnd) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StBusRst: begin
        if (cnt_q == RstEnd) begin
          bus_reset_done = 1'b1;
          cnt_d          = '0;
          state_d        = StGuard;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Pad levels decoded from the next state so pads change on the same edge as the state.
  always_comb begin
    pad_t_d = 1'b1;
    dp_d    = 1'b0;
    dm_d    = 1'b0;
    unique case (state_d)
      StTxData: begin
        pad_t_d = 1'b0;
        dp_d    = bit_d;
        dm_d    = ~bit_d;
      end
      StEopJ: begin
        pad_t_d = 1'b0;
        dp_d    = 1'b1;
      end
      StEopSe0, StBusRst: begin
        pad_t_d = 1'b0;
      end
      default: begin
        pad_t_d = 1'b1;
      end
    endcase
  end

  // Sequencer state, counter and registered pad drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
      pad_t_q <= 1'b1;
      dp_q    <= 1'b0;
      dm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      pad_t_q <= pad_t_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {dp_i, dm_i};
      sync2_q <= sync1_q;
    end
  end

  // One tristate flop feeds both pads so they can never disagree.
  assign dp_t       = pad_t_q;
  assign dm_t       = pad_t_q;
  assign dp_o       = dp_q;
  assign dm_o       = dm_q;
  assign busy       = (state_q != StIdle);
  assign line_state = sync2_q;

endmodule

// File: tb/tb_usb_fs_pad_seq.sv
// Self-checking bench for usb_fs_pad_seq: directed table, hand sequences, random traffic.
module tb_usb_fs_pad_seq;

  localparam int CPB  = 4;
  localparam int TB   = 2;
  localparam int RC   = 16;
  localparam int MAXC = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_bit, tx_last, tx_ready, tx_underrun, eop_done;
  logic       bus_reset_req, bus_reset_done, busy;
  logic [1:0] line_state;
  logic       dp_o, dm_o, dp_t, dm_t, dp_i, dm_i;

  always #5 clk = ~clk;

  usb_fs_pad_seq #(
    .CLKS_PER_BIT(CPB),
    .TURNAROUND_BITS(TB),
    .RESET_CYCLES(RC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_bit(tx_bit),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .tx_underrun(tx_underrun),
    .eop_done(eop_done),
    .bus_reset_req(bus_reset_req),
    .bus_reset_done(bus_reset_done),
    .busy(busy),
    .line_state(line_state),
    .dp_o(dp_o),
    .dm_o(dm_o),
    .dp_t(dp_t),
    .dm_t(dm_t),
    .dp_i(dp_i),
    .dm_i(dm_i)
  );

  typedef struct packed {
    logic ready, underrun, eop, rdone, busy, dpt, dmt, dp, dm;
  } exp_t;

  typedef struct {
    bit          is_rst;
    int          n;
    logic [15:0] bits;
    bit          full;
    int          eop;
    int          done;
    int          und;
    int          idle;
  } vec_t;

  exp_t exp_tr [MAXC];
  logic st_valid [MAXC];
  logic st_bit [MAXC];
  logic st_last [MAXC];
  logic st_req [MAXC];
  int   tr_len;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] ls_one, ls_two;
  int   obs_eop, obs_done, obs_und, obs_idle;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Advance one cycle, shifting the pad-input delay line used for line_state.
  task automatic cyc_end();
    ls_two = ls_one;
    ls_one = {dp_i, dm_i};
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.dpt = 1'b1;
    e.dmt = 1'b1;
    return e;
  endfunction

  function automatic exp_t drv_e(input logic dp, input logic dm);
    exp_t e = '0;
    e.busy = 1'b1;
    e.dp   = dp;
    e.dm   = dm;
    return e;
  endfunction

  task automatic build_idle(input int g);
    tr_len = g;
    for (int c = 0; c < g; c++) begin
      exp_tr[c] = idle_e();
      st_valid[c] = 1'b0;
      st_req[c]   = 1'b0;
      st_bit[c]   = 1'($urandom);
      st_last[c]  = 1'($urandom);
    end
  endtask

  // Packet of n bits; full=1 marks bit n-1 last, otherwise the stream underruns after it.
  task automatic build_packet(input int n, input logic [15:0] bits, input bit full);
    int b0;
    tr_len = 4 * n + 22;
    b0 = 4 * n;
    for (int c = 0; c < tr_len; c++) begin
      exp_tr[c] = idle_e();
      st_valid[c] = 1'b0;
      st_req[c]   = 1'b0;
      st_bit[c]   = 1'($urandom);
      st_last[c]  = 1'($urandom);
      if ((c >= 1 && c < b0) || (c > b0 && c <= b0 + 20)) begin
        st_valid[c] = 1'($urandom);
        st_req[c]   = 1'($urandom);
      end
    end
    for (int c = 1; c <= b0; c++) begin
      logic b;
      b = bits[(c - 1) / 4];
      exp_tr[c] = drv_e(b, ~b);
    end
    for (int c = b0 + 1; c <= b0 + 8; c++) exp_tr[c] = drv_e(1'b0, 1'b0);
    for (int c = b0 + 9; c <= b0 + 12; c++) exp_tr[c] = drv_e(1'b1, 1'b0);
    for (int c = b0 + 13; c <= b0 + 20; c++) begin
      exp_tr[c] = idle_e();
      exp_tr[c].busy = 1'b1;
    end
    exp_tr[b0 + 12].eop = 1'b1;
    if (!full) exp_tr[b0].underrun = 1'b1;
    for (int k = 0; k < n; k++) begin
      st_valid[4 * k] = 1'b1;
      st_req[4 * k]   = 1'b0;
      st_bit[4 * k]   = bits[k];
      st_last[4 * k]  = full && (k == n - 1);
      exp_tr[4 * k].ready = 1'b1;
    end
  endtask

  task automatic build_reset();
    tr_len = 26;
    for (int c = 0; c < tr_len; c++) begin
      exp_tr[c] = idle_e();
      st_valid[c] = (c < 25) ? 1'($urandom) : 1'b0;
      st_req[c]   = (c < 25) ? 1'($urandom) : 1'b0;
      st_bit[c]   = 1'($urandom);
      st_last[c]  = 1'($urandom);
    end
    st_req[0] = 1'b1;
    for (int c = 1; c <= RC; c++) exp_tr[c] = drv_e(1'b0, 1'b0);
    exp_tr[RC].rdone = 1'b1;
    for (int c = RC + 1; c <= RC + 8; c++) begin
      exp_tr[c] = idle_e();
      exp_tr[c].busy = 1'b1;
    end
  endtask

  task automatic run_trace(input string name);
    exp_t act;
    obs_eop  = -1;
    obs_done = -1;
    obs_und  = -1;
    obs_idle = -1;
    for (int c = 0; c < tr_len; c++) begin
      tx_valid      = st_valid[c];
      tx_bit        = st_bit[c];
      tx_last       = st_last[c];
      bus_reset_req = st_req[c];
      {dp_i, dm_i}  = 2'($urandom);
      @(negedge clk);
      act = {tx_ready, tx_underrun, eop_done, bus_reset_done, busy, dp_t, dm_t, dp_o, dm_o};
      check($sformatf("%s c%0d outs", name, c), 32'(act), 32'(exp_tr[c]));
      check($sformatf("%s c%0d line_state", name, c), 32'(line_state), 32'(ls_two));
      if (eop_done && obs_eop < 0) obs_eop = c;
      if (bus_reset_done && obs_done < 0) obs_done = c;
      if (tx_underrun && obs_und < 0) obs_und = c;
      if (c > 0 && !busy && obs_idle < 0) obs_idle = c;
      cyc_end();
    end
  endtask

  // Valid held high through a packet or bus reset; the next accept must wait for IDLE.
  task automatic hold_check(input bit is_rst);
    int k;
    for (int c = 0; c <= 26; c++) begin
      tx_valid      = 1'b1;
      tx_bit        = 1'b1;
      tx_last       = 1'b1;
      bus_reset_req = is_rst && (c == 0);
      @(negedge clk);
      check($sformatf("hold%0d c%0d ready", is_rst, c), 32'(tx_ready),
            32'((c == 25) || (c == 0 && !is_rst)));
      if (c == 26) check($sformatf("hold%0d pads", is_rst), {dp_t, dm_t, dp_o, dm_o}, 4'b0010);
      cyc_end();
    end
    tx_valid = 1'b0;
    k = 0;
    while (busy && k < 60) begin
      cyc_end();
      k++;
    end
    check($sformatf("hold%0d drain", is_rst), 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 3, 16'h0005, 1, 24, -1, -1, 33};
    vt[1] = '{0, 1, 16'h0001, 0, 16, -1, 4, 25};
    vt[2] = '{0, 2, 16'h0002, 1, 20, -1, -1, 29};
    vt[3] = '{1, 0, 16'h0000, 0, -1, 16, -1, 25};
    vt[4] = '{0, 5, 16'h000d, 0, 32, -1, 20, 41};

    rst = 1'b1;
    tx_valid = 1'b0; tx_bit = 1'b0; tx_last = 1'b0; bus_reset_req = 1'b0;
    dp_i = 1'b0; dm_i = 1'b0;
    ls_one = 2'b00; ls_two = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset pads", {dp_t, dm_t, dp_o, dm_o}, 4'b1100);
    check("reset busy", 32'(busy), 32'd0);
    check("reset pulses", {tx_ready, tx_underrun, eop_done, bus_reset_done}, 4'b0000);
    check("reset line_state", 32'(line_state), 32'd0);
    rst = 1'b0;
    cyc_end();

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      if (vt[i].is_rst) build_reset();
      else build_packet(vt[i].n, vt[i].bits, vt[i].full);
      run_trace($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d eop cycle", i), 32'(obs_eop), 32'(vt[i].eop));
      check($sformatf("tbl%0d reset_done cycle", i), 32'(obs_done), 32'(vt[i].done));
      check($sformatf("tbl%0d underrun cycle", i), 32'(obs_und), 32'(vt[i].und));
      check($sformatf("tbl%0d idle cycle", i), 32'(obs_idle), 32'(vt[i].idle));
    end

    // Held requests wait out guard time.
    dp_i = 1'b0; dm_i = 1'b0;
    hold_check(1'b1);
    hold_check(1'b0);

    // Async reset mid-bit releases pads without a clock edge.
    tx_valid = 1'b1; tx_bit = 1'b0; tx_last = 1'b0;
    cyc_end();
    tx_valid = 1'b0;
    cyc_end();
    @(negedge clk);
    check("pre-rst pads", {dp_t, dm_t, dp_o, dm_o}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("async rst pads", {dp_t, dm_t, dp_o, dm_o}, 4'b1100);
    check("async rst busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ls_one = 2'b00; ls_two = 2'b00;
    cyc_end();
    build_packet(3, 16'h0005, 1'b1);
    run_trace("post-rst");

    // Loopback synchroniser latency while idle.
    dp_i = 1'b0; dm_i = 1'b0;
    repeat (3) cyc_end();
    dp_i = 1'b0; dm_i = 1'b1;
    @(negedge clk);
    check("ls lat0", 32'(line_state), 32'd0);
    cyc_end();
    @(negedge clk);
    check("ls lat1", 32'(line_state), 32'd0);
    cyc_end();
    @(negedge clk);
    check("ls lat2", 32'(line_state), 32'b01);
    cyc_end();

    // Random traffic against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      build_idle(int'($urandom_range(0, 3)));
      run_trace($sformatf("rnd%0d gap", i));
      if ($urandom_range(0, 4) == 0) begin
        build_reset();
      end else begin
        build_packet(int'($urandom_range(1, 8)), 16'($urandom), 1'($urandom));
      end
      run_trace($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
